if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues word reads on the instruction bus, and delivers
//  (inst, pc, valid) to the IF/ID boundary feeding the decoder (id_type).
//  Applies branch redirects from ID (MIPS delay-slot semantics), exception/ERET redirects, and
//  pipeline stalls. Flags misaligned-PC fetch (AdEL) without touching the bus.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000   PC fetched first after reset
// PORTS
//  clk            in   1    system clock; all state on rising edge
//  rst_n          in   1    synchronous, active-low reset
//  stall          in   1    downstream cannot accept; hold delivered inst
//  br_flag        in   1    ID resolved taken branch/jump (1-cycle pulse)
//  br_target      in   32   branch target
//  exc_flag       in   1    exception/ERET redirect (1-cycle pulse), kills in-flight fetch
//  exc_target     in   32   handler / EPC address
//  ibus_req       out  1    read request; held with ibus_addr stable until ibus_ack
//  ibus_addr      out  32   word address (bits[1:0]=0)
//  ibus_ack       in   1    1-cycle; ibus_rdata valid same cycle
//  ibus_rdata     in   32   fetched word
//  if_inst        out  32   instruction to ID (Inst_t)
//  if_pc          out  32   PC of if_inst
//  if_valid       out  1    if_inst/if_pc meaningful
//  if_exc_adel    out  1    if_pc misaligned; if_inst forced to 0 (NOP)
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset rst_n is synchronous and active-low.
//  Reset: pc=RESET_PC, state=S_REQ, ibus_req=0 during reset, if_valid=0, if_inst=0,
//   if_pc=0, if_exc_adel=0, kill=0, br_pend=0. First request is issued the cycle after rst_n rises.
//  FSM states S_REQ, S_HOLD, S_ADEL.
//   S_REQ: ibus_req=1, ibus_addr=pc. On ack: if kill, discard rdata and clear kill; else latch
//    if_inst=rdata, if_pc=pc, if_valid=1; next pc per priority below; stay S_REQ if !stall,
//    else go S_HOLD. No ack: if_valid drops to 0 once the downstream accepts (stall=0).
//   S_HOLD: ibus_req=0; outputs frozen; stall=0 -> S_REQ with next pc.
//   S_ADEL: entered when pc[1:0]!=0 in S_REQ (no request issued); present if_valid=1,
//    if_exc_adel=1, if_inst=0, if_pc=pc; wait for exc_flag.
//  Next-pc priority: exc_flag > br_pend > pc+4 (32-bit wrap, no carry out).
//  Branch: br_flag records br_pend/br_tgt. The next instruction delivered after the branch is
//   the delay slot and is kept; the fetch after it uses br_tgt; br_pend then clears.
//   br_flag while a fetch is outstanding marks that fetch as the delay slot.
//  Exception: exc_flag clears br_pend, drops if_valid next cycle. Outstanding request (req=1,
//   no ack yet): set kill, keep addr stable, refetch exc_target after the ack.
//   exc_flag on the ack cycle: discard rdata in that same cycle.
//   exc_flag in S_HOLD or S_ADEL: go S_REQ at exc_target.
//  exc_flag and br_flag together: exception wins; branch is dropped.
//  stall and ack in the same cycle: data is latched, then the FSM holds.
//  A redirect never changes ibus_addr mid-request.
//  Reset mid-request: state cleared; a late ack is ignored because ibus_req is low.
// STRUCTURE
//  cpu_defines.svh: Inst_t, Word_t, Bit_t, RESET_PC default, ZERO_WORD, fetch-state enum Fetch_state_t.
//  One sub-module, if_pc_next (combinational next-pc select: exc/branch/seq).
//  Everything else inline.
// TESTING
//  1. Reset release, ack every cycle -> addrs BFC00000, BFC00004, 08...
//     if_pc tracks; if_valid=1 from 2nd cycle.
//  2. br_flag target 0x80001000 while fetching 0x..0C -> 0x..0C delivered (delay slot),
//     next addr 0x80001000.
//  3. exc_flag target 0x80000180 while a request is outstanding with ack delayed 3 cycles
//     -> ibus_addr held; rdata discarded; next addr 0x80000180; no if_valid for the killed word.
//  4. stall=1 for 4 cycles at ack -> if_inst/if_pc frozen, ibus_req=0;
//     stall drop -> next addr = pc+4.
//  5. exc_target 0x80000182 -> no ibus_req; if_exc_adel=1, if_inst=0, if_pc=0x80000182;
//     then exc_flag 0x80000180 resumes.
//  6. pc 0xFFFFFFFC, ack -> next addr 0x00000000; rst_n=0 mid-request -> ibus_req=0, all outputs 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types, constants and fetch-state encoding for the instruction-fetch stage.
// No logic here beyond a tiny alignment helper.
package if_fetch_pkg;
   typedef logic [31:0] word_t;
   typedef word_t       inst_t;

   localparam word_t RESET_PC_DEF = 32'hBFC0_0000;
   localparam word_t ZERO_WORD    = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_ADEL = 2'd2
   } fetch_state_t;

   function automatic logic pc_aligned(input word_t a);
      return a[1:0] == 2'b00;
   endfunction
endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: pipeline control in, instruction bus, and IF/ID outputs.
// master = fetch stage, slave = pipeline/memory side.
interface if_fetch_if;
   import if_fetch_pkg::*;

   logic  stall;
   logic  br_flag;
   word_t br_target;
   logic  exc_flag;
   word_t exc_target;
   logic  ibus_req;
   word_t ibus_addr;
   logic  ibus_ack;
   word_t ibus_rdata;
   inst_t if_inst;
   word_t if_pc;
   logic  if_valid;
   logic  if_exc_adel;

   modport master (
      input  stall, br_flag, br_target, exc_flag, exc_target, ibus_ack, ibus_rdata,
      output ibus_req, ibus_addr, if_inst, if_pc, if_valid, if_exc_adel
   );

   modport slave (
      output stall, br_flag, br_target, exc_flag, exc_target, ibus_ack, ibus_rdata,
      input  ibus_req, ibus_addr, if_inst, if_pc, if_valid, if_exc_adel
   );
endinterface

// File: rtl/if_fetch_pc_next.sv
// Combinational next-PC select: redirect (exception/kill) > pending branch > sequential.
// Zero latency; sequential step wraps at 32 bits.
module if_fetch_pc_next
   import if_fetch_pkg::*;
(
   input  logic  redir,
   input  word_t redir_pc,
   input  logic  br,
   input  word_t br_pc,
   input  word_t pc,
   output word_t next_pc
);
   always_comb begin
      next_pc = pc + 32'd4;
      if (redir)   next_pc = redir_pc;
      else if (br) next_pc = br_pc;
   end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues word reads, delivers (inst, pc, valid) to ID; 1-cycle ack-to-output.
// Stall with data latched parks in S_HOLD with the bus idle; redirects never disturb an outstanding request.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEF
)(
   input  logic          clk,
   input  logic          rst_n,
   if_fetch_if.master    bus
);
   fetch_state_t state, state_n;
   word_t        pc, pc_n;
   logic         kill, kill_n;
   word_t        kill_tgt, kill_tgt_n;
   logic         br_pend, br_pend_n;
   word_t        br_tgt, br_tgt_n;
   inst_t        inst_q, inst_n;
   word_t        ipc_q, ipc_n;
   logic         valid_q, valid_n;
   logic         adel_q, adel_n;

   logic         aligned;
   logic         req;
   logic         fire;
   word_t        next_pc;

   assign aligned = pc_aligned(pc);
   // Gated by rst_n so a late ack during reset can never be taken.
   assign req     = rst_n && (state == S_REQ) && aligned;
   assign fire    = req && bus.ibus_ack;

   if_fetch_pc_next u_pc_next (
      .redir    (bus.exc_flag | kill),
      .redir_pc (bus.exc_flag ? bus.exc_target : kill_tgt),
      .br       (bus.br_flag | br_pend),
      .br_pc    (bus.br_flag ? bus.br_target : br_tgt),
      .pc       (pc),
      .next_pc  (next_pc)
   );

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      kill_n     = kill;
      kill_tgt_n = kill_tgt;
      br_pend_n  = br_pend;
      br_tgt_n   = br_tgt;
      inst_n     = inst_q;
      ipc_n      = ipc_q;
      valid_n    = valid_q;
      adel_n     = adel_q;

      if (bus.br_flag) begin
         br_pend_n = 1'b1;
         br_tgt_n  = bus.br_target;
      end

      unique case (state)
         S_REQ: begin
            if (!aligned) begin
               if (bus.exc_flag) begin
                  pc_n = bus.exc_target;
               end else begin
                  state_n = S_ADEL;
                  valid_n = 1'b1;
                  adel_n  = 1'b1;
                  inst_n  = ZERO_WORD;
                  ipc_n   = pc;
               end
            end else if (fire) begin
               pc_n = next_pc;
               if (kill || bus.exc_flag) begin
                  kill_n  = 1'b0;
                  valid_n = valid_q & bus.stall;
               end else begin
                  // This word is the delay slot if a branch is pending, so it is kept.
                  inst_n    = bus.ibus_rdata;
                  ipc_n     = pc;
                  valid_n   = 1'b1;
                  adel_n    = 1'b0;
                  br_pend_n = 1'b0;
                  if (bus.stall) state_n = S_HOLD;
               end
            end else begin
               valid_n = valid_q & bus.stall;
               if (bus.exc_flag) begin
                  kill_n     = 1'b1;
                  kill_tgt_n = bus.exc_target;
               end
            end
         end
         S_HOLD: begin
            if (bus.exc_flag) begin
               state_n = S_REQ;
               pc_n    = bus.exc_target;
            end else if (!bus.stall) begin
               state_n = S_REQ;
               valid_n = 1'b0;
            end
         end
         S_ADEL: begin
            if (bus.exc_flag) begin
               state_n = S_REQ;
               pc_n    = bus.exc_target;
            end
         end
         default: state_n = S_REQ;
      endcase

      if (bus.exc_flag) begin
         br_pend_n = 1'b0;
         valid_n   = 1'b0;
         adel_n    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         kill     <= 1'b0;
         kill_tgt <= ZERO_WORD;
         br_pend  <= 1'b0;
         br_tgt   <= ZERO_WORD;
         inst_q   <= ZERO_WORD;
         ipc_q    <= ZERO_WORD;
         valid_q  <= 1'b0;
         adel_q   <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         kill     <= kill_n;
         kill_tgt <= kill_tgt_n;
         br_pend  <= br_pend_n;
         br_tgt   <= br_tgt_n;
         inst_q   <= inst_n;
         ipc_q    <= ipc_n;
         valid_q  <= valid_n;
         adel_q   <= adel_n;
      end
   end

   assign bus.ibus_req    = req;
   assign bus.ibus_addr   = pc;
   assign bus.if_inst     = inst_q;
   assign bus.if_pc       = ipc_q;
   assign bus.if_valid    = valid_q;
   assign bus.if_exc_adel = adel_q;
endmodule

// File: tb/tb_if_fetch.sv
// Directed scenarios then random traffic, each cycle checked against a transaction-level fetch model.
module tb_if_fetch;
   import if_fetch_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   if_fetch_if bus();

   if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: address the next kept fetch must use, pending delay-slot branch, discard of a killed fetch.
   word_t m_next, m_held, m_tgt, m_inst, m_pc;
   logic  m_pend, m_discard, m_valid, m_hold, m_adel;

   function automatic word_t mem(input word_t a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_next = 32'hBFC0_0000; m_held = '0; m_tgt = '0; m_inst = '0; m_pc = '0;
      m_pend = 1'b0; m_discard = 1'b0; m_valid = 1'b0; m_hold = 1'b0; m_adel = 1'b0;
   endtask

   function automatic logic m_req();
      return !m_hold && !m_adel && (m_discard || m_next[1:0] == 2'b00);
   endfunction

   task automatic check_outputs();
      chk("ibus_req", 32'(bus.ibus_req), 32'(m_req()));
      if (m_req()) chk("ibus_addr", bus.ibus_addr, m_discard ? m_held : m_next);
      chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
      chk("if_exc_adel", 32'(bus.if_exc_adel), 32'(m_adel));
      if (m_valid) begin
         chk("if_inst", bus.if_inst, m_inst);
         chk("if_pc", bus.if_pc, m_pc);
      end
   endtask

   // Called just after a falling edge: check, drive one cycle of inputs, advance the model.
   task automatic step(input logic st, input logic ack, input logic br, input word_t bt,
                       input logic ex, input word_t et);
      logic req_e;
      logic fire;
      check_outputs();
      req_e = m_req();
      fire  = req_e && ack;
      bus.stall      = st;
      bus.ibus_ack   = fire;
      bus.ibus_rdata = fire ? mem(bus.ibus_addr) : 32'hDEAD_BEEF;
      bus.br_flag    = br;
      bus.br_target  = bt;
      bus.exc_flag   = ex;
      bus.exc_target = et;

      if (ex) begin
         if (req_e && !ack) begin
            if (!m_discard) m_held = m_next;
            m_discard = 1'b1;
         end else if (fire) begin
            m_discard = 1'b0;
         end
         m_next = et; m_pend = 1'b0; m_valid = 1'b0; m_hold = 1'b0; m_adel = 1'b0;
      end else begin
         if (br) begin
            m_pend = 1'b1;
            m_tgt  = bt;
         end
         if (fire) begin
            if (m_discard) begin
               m_discard = 1'b0;
               m_valid   = m_valid & st;
            end else begin
               m_inst  = mem(m_next);
               m_pc    = m_next;
               m_valid = 1'b1;
               m_hold  = st;
               m_next  = m_pend ? m_tgt : m_next + 32'd4;
               m_pend  = 1'b0;
            end
         end else if (!m_adel) begin
            if (!m_hold && !m_discard && m_next[1:0] != 2'b00) begin
               m_adel = 1'b1; m_valid = 1'b1; m_inst = '0; m_pc = m_next;
            end else begin
               m_valid = m_valid & st;
               m_hold  = m_hold & st;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic  st, ak, br, ex;
      word_t bt, et;

      bus.stall = 1'b0; bus.br_flag = 1'b0; bus.br_target = '0;
      bus.exc_flag = 1'b0; bus.exc_target = '0;
      bus.ibus_ack = 1'b1; bus.ibus_rdata = 32'h1111_2222;
      model_reset();

      // Reset state, with a stray ack on the bus.
      repeat (3) @(negedge clk);
      chk("rst ibus_req", 32'(bus.ibus_req), 32'd0);
      chk("rst if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst if_inst", bus.if_inst, 32'd0);
      chk("rst if_pc", bus.if_pc, 32'd0);
      chk("rst if_exc_adel", 32'(bus.if_exc_adel), 32'd0);
      bus.ibus_ack = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("t1 first addr", bus.ibus_addr, 32'hBFC0_0000);

      // 1: ack every cycle, sequential addresses.
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 0, '0, 0, '0);
         chk("t1 addr", bus.ibus_addr, 32'hBFC0_0000 + 32'(4 * i));
         chk("t1 if_pc", bus.if_pc, 32'hBFC0_0000 + 32'(4 * (i - 1)));
      end

      // 2: branch while 0x..0C outstanding; 0C is the delay slot.
      step(0, 0, 1, 32'h8000_1000, 0, '0);
      step(0, 1, 0, '0, 0, '0);
      chk("t2 delay slot pc", bus.if_pc, 32'hBFC0_000C);
      chk("t2 branch addr", bus.ibus_addr, 32'h8000_1000);

      // 3: exception during an outstanding fetch whose ack is delayed 3 cycles.
      step(0, 1, 0, '0, 0, '0);
      step(0, 0, 0, '0, 1, 32'h8000_0180);
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, '0, 0, '0);
         chk("t3 held addr", bus.ibus_addr, 32'h8000_1004);
      end
      step(0, 1, 0, '0, 0, '0);
      chk("t3 killed valid", 32'(bus.if_valid), 32'd0);
      chk("t3 handler addr", bus.ibus_addr, 32'h8000_0180);
      step(0, 1, 0, '0, 0, '0);
      chk("t3 handler pc", bus.if_pc, 32'h8000_0180);

      // 4: stall on the ack cycle, held for 4 more cycles.
      step(1, 1, 0, '0, 0, '0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, '0, 0, '0);
         chk("t4 req low", 32'(bus.ibus_req), 32'd0);
         chk("t4 frozen pc", bus.if_pc, 32'h8000_0184);
      end
      step(0, 0, 0, '0, 0, '0);
      chk("t4 resume addr", bus.ibus_addr, 32'h8000_0188);

      // 5: misaligned exception target from the hold state.
      step(1, 1, 0, '0, 0, '0);
      step(0, 0, 0, '0, 1, 32'h8000_0182);
      chk("t5 no req", 32'(bus.ibus_req), 32'd0);
      step(0, 0, 0, '0, 0, '0);
      chk("t5 adel", 32'(bus.if_exc_adel), 32'd1);
      chk("t5 inst", bus.if_inst, 32'd0);
      chk("t5 pc", bus.if_pc, 32'h8000_0182);
      step(1, 0, 0, '0, 0, '0);
      step(0, 0, 0, '0, 1, 32'h8000_0180);
      chk("t5 resume addr", bus.ibus_addr, 32'h8000_0180);

      // 6: PC wrap, then reset mid-request with a late ack.
      step(0, 0, 0, '0, 1, 32'hFFFF_FFFC);
      step(0, 1, 0, '0, 0, '0);
      chk("t6 wrap fetch", bus.ibus_addr, 32'hFFFF_FFFC);
      step(0, 1, 0, '0, 0, '0);
      chk("t6 wrapped addr", bus.ibus_addr, 32'h0000_0000);
      rst_n = 1'b0;
      bus.ibus_ack = 1'b1;
      bus.ibus_rdata = 32'h1234_5678;
      #1;
      chk("t6 req in reset", 32'(bus.ibus_req), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("t6 valid", 32'(bus.if_valid), 32'd0);
      chk("t6 inst", bus.if_inst, 32'd0);
      chk("t6 pc", bus.if_pc, 32'd0);
      chk("t6 adel", 32'(bus.if_exc_adel), 32'd0);
      bus.ibus_ack = 1'b0;
      rst_n = 1'b1;
      model_reset();
      #1;
      chk("t6 restart addr", bus.ibus_addr, 32'hBFC0_0000);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         st = ($urandom_range(0, 3) == 0);
         ak = ($urandom_range(0, 1) == 1);
         br = ($urandom_range(0, 11) == 0);
         ex = ($urandom_range(0, 24) == 0);
         bt = $urandom & 32'hFFFF_FFFC;
         et = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) et[1:0] = 2'($urandom_range(1, 3));
         step(st, ak, br, bt, ex, et);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
